// File: rtl/hazard_scoreboard_if.sv
// Issue-side handshake between the instruction issue stage and the hazard scoreboard.
// The issue stage drives the candidate instruction; the scoreboard answers with stall/issue_ack.
interface hazard_scoreboard_if #(
  parameter int ADDR_W = 3,
  parameter int LAT_W  = 3
);
  logic              issue_valid;
  logic              issue_wen;
  logic [ADDR_W-1:0] issue_dest;
  logic [LAT_W-1:0]  issue_lat;
  logic [ADDR_W-1:0] src_1;
  logic [ADDR_W-1:0] src_2;
  logic              src_1_used;
  logic              src_2_used;
  logic              stall;
  logic              issue_ack;

  modport master (
    output issue_valid, issue_wen, issue_dest, issue_lat,
    output src_1, src_2, src_1_used, src_2_used,
    input  stall, issue_ack
  );

  modport slave (
    input  issue_valid, issue_wen, issue_dest, issue_lat,
    input  src_1, src_2, src_1_used, src_2_used,
    output stall, issue_ack
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register-write hazard scoreboard: one result-latency countdown per architectural
// register, combinational RAW stall for the presented instruction, saturating stall counter.
module hazard_scoreboard #(
  parameter int ADDR_W = 3,
  parameter int LAT_W  = 3,
  parameter int FWD_EN = 1,
  parameter int PERF_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hazard_en,
  input  logic                     flush,
  hazard_scoreboard_if.slave       issue,
  output logic [(2**ADDR_W)-1:0]   busy,
  output logic [PERF_W-1:0]        stall_count
);

  localparam int NUM_REGS = 2**ADDR_W;

  logic [LAT_W-1:0] cnt_q [1:NUM_REGS-1];
  logic [LAT_W-1:0] cnt_src_1;
  logic [LAT_W-1:0] cnt_src_2;
  logic             hit_1;
  logic             hit_2;
  logic             stall_c;
  logic             ack_c;
  logic             load;

  // With forwarding, a result one cycle from writeback can be bypassed, so only cnt > 1 blocks.
  function automatic logic pending(input logic [LAT_W-1:0] c);
    if (FWD_EN != 0) return c > LAT_W'(1);
    else             return c != '0;
  endfunction

  always_comb begin
    cnt_src_1 = '0;
    cnt_src_2 = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issue.src_1 == ADDR_W'(r)) cnt_src_1 = cnt_q[r];
      if (issue.src_2 == ADDR_W'(r)) cnt_src_2 = cnt_q[r];
    end
  end

  assign hit_1   = issue.src_1_used && (issue.src_1 != '0) && pending(cnt_src_1);
  assign hit_2   = issue.src_2_used && (issue.src_2 != '0) && pending(cnt_src_2);
  assign stall_c = hazard_en && issue.issue_valid && !flush && (hit_1 || hit_2);
  assign ack_c   = issue.issue_valid && !stall_c && !flush;
  assign load    = ack_c && issue.issue_wen && (issue.issue_dest != '0);

  assign issue.stall     = stall_c;
  assign issue.issue_ack = ack_c;

  always_comb begin
    busy = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  // A fresh issue overrides the decrement of its destination (latest issue wins on WAW).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 1; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else if (flush) begin
      for (int r = 1; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (load && (issue.issue_dest == ADDR_W'(r))) begin
          cnt_q[r] <= issue.issue_lat;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - LAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (stall_c && (stall_count != {PERF_W{1'b1}})) begin
      stall_count <= stall_count + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table on the forwarding instance plus
// hand sequences for non-forwarding timing, async reset and counter saturation.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       he, fl, iv, wen, s1u, s2u;
  logic [2:0] dest, lat, s1, s2;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_scoreboard_if #(.ADDR_W(3), .LAT_W(3)) bus_f ();
  hazard_scoreboard_if #(.ADDR_W(3), .LAT_W(3)) bus_n ();
  hazard_scoreboard_if #(.ADDR_W(3), .LAT_W(3)) bus_s ();

  assign bus_f.issue_valid = iv;   assign bus_n.issue_valid = iv;   assign bus_s.issue_valid = iv;
  assign bus_f.issue_wen   = wen;  assign bus_n.issue_wen   = wen;  assign bus_s.issue_wen   = wen;
  assign bus_f.issue_dest  = dest; assign bus_n.issue_dest  = dest; assign bus_s.issue_dest  = dest;
  assign bus_f.issue_lat   = lat;  assign bus_n.issue_lat   = lat;  assign bus_s.issue_lat   = lat;
  assign bus_f.src_1       = s1;   assign bus_n.src_1       = s1;   assign bus_s.src_1       = s1;
  assign bus_f.src_2       = s2;   assign bus_n.src_2       = s2;   assign bus_s.src_2       = s2;
  assign bus_f.src_1_used  = s1u;  assign bus_n.src_1_used  = s1u;  assign bus_s.src_1_used  = s1u;
  assign bus_f.src_2_used  = s2u;  assign bus_n.src_2_used  = s2u;  assign bus_s.src_2_used  = s2u;

  logic [7:0]  busy_f, busy_n, busy_s;
  logic [15:0] sc_f, sc_n;
  logic [1:0]  sc_s;

  hazard_scoreboard #(.ADDR_W(3), .LAT_W(3), .FWD_EN(1), .PERF_W(16)) u_fwd (
    .clk(clk), .rst(rst), .hazard_en(he), .flush(fl), .issue(bus_f),
    .busy(busy_f), .stall_count(sc_f));

  hazard_scoreboard #(.ADDR_W(3), .LAT_W(3), .FWD_EN(0), .PERF_W(16)) u_nofwd (
    .clk(clk), .rst(rst), .hazard_en(he), .flush(fl), .issue(bus_n),
    .busy(busy_n), .stall_count(sc_n));

  hazard_scoreboard #(.ADDR_W(3), .LAT_W(3), .FWD_EN(1), .PERF_W(2)) u_sat (
    .clk(clk), .rst(rst), .hazard_en(he), .flush(fl), .issue(bus_s),
    .busy(busy_s), .stall_count(sc_s));

  typedef struct {
    logic       he, fl, iv, wen;
    logic [2:0] dest, lat, s1;
    logic       s1u;
    logic [2:0] s2;
    logic       s2u;
    logic       stall, ack;
    logic [7:0] busy;
    logic [15:0] sc;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic h, f, v, w, input logic [2:0] d, l, a,
                              input logic au, input logic [2:0] b, input logic bu,
                              input logic st, ak, input logic [7:0] bz, input logic [15:0] c);
    vec_t t;
    t.he = h; t.fl = f; t.iv = v; t.wen = w; t.dest = d; t.lat = l;
    t.s1 = a; t.s1u = au; t.s2 = b; t.s2u = bu;
    t.stall = st; t.ack = ak; t.busy = bz; t.sc = c;
    return t;
  endfunction

  task automatic drive(input logic h, f, v, w, input logic [2:0] d, l, a,
                       input logic au, input logic [2:0] b, input logic bu);
    he = h; fl = f; iv = v; wen = w; dest = d; lat = l;
    s1 = a; s1u = au; s2 = b; s2u = bu;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int stalls, busy_cyc;
    logic acked;

    //           he fl iv we de la s1 u  s2 u   st ak busy   sc
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 0);
    vecs[1]  = mk(1, 0, 1, 1, 3, 3, 0, 0, 0, 0,  0, 1, 8'h00, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h08, 0);
    vecs[3]  = mk(1, 0, 1, 0, 0, 0, 3, 1, 0, 0,  1, 0, 8'h08, 0);
    vecs[4]  = mk(1, 0, 1, 0, 0, 0, 3, 1, 0, 0,  0, 1, 8'h08, 1);
    vecs[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 1);
    vecs[6]  = mk(1, 0, 1, 1, 5, 4, 0, 0, 0, 0,  0, 1, 8'h00, 1);
    vecs[7]  = mk(1, 0, 1, 0, 0, 0, 0, 1, 5, 0,  0, 1, 8'h20, 1);
    vecs[8]  = mk(1, 0, 1, 1, 0, 5, 0, 0, 0, 0,  0, 1, 8'h20, 1);
    vecs[9]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 5, 1,  1, 0, 8'h20, 1);
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h20, 2);
    vecs[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 2);
    vecs[12] = mk(1, 0, 1, 1, 5, 6, 0, 0, 0, 0,  0, 1, 8'h00, 2);
    vecs[13] = mk(1, 1, 1, 0, 0, 0, 5, 1, 0, 0,  0, 0, 8'h20, 2);
    vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 2);
    vecs[15] = mk(1, 0, 1, 1, 2, 5, 0, 0, 0, 0,  0, 1, 8'h00, 2);
    vecs[16] = mk(0, 0, 1, 0, 0, 0, 2, 1, 0, 0,  0, 1, 8'h04, 2);
    vecs[17] = mk(1, 0, 1, 1, 2, 1, 0, 0, 0, 0,  0, 1, 8'h04, 2);
    vecs[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h04, 2);
    vecs[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 2);
    vecs[20] = mk(1, 0, 1, 1, 4, 2, 0, 0, 0, 0,  0, 1, 8'h00, 2);
    vecs[21] = mk(1, 0, 1, 1, 4, 7, 4, 1, 0, 0,  1, 0, 8'h10, 2);
    vecs[22] = mk(1, 0, 1, 1, 4, 7, 4, 1, 0, 0,  0, 1, 8'h10, 3);
    vecs[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h10, 3);
    vecs[24] = mk(1, 0, 1, 1, 4, 0, 0, 0, 0, 0,  0, 1, 8'h10, 3);
    vecs[25] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 3);
    vecs[26] = mk(1, 0, 1, 1, 6, 3, 0, 0, 0, 0,  0, 1, 8'h00, 3);
    vecs[27] = mk(1, 0, 0, 0, 0, 0, 6, 1, 0, 0,  0, 0, 8'h40, 3);
    vecs[28] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h40, 3);
    vecs[29] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h40, 3);
    vecs[30] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 8'h00, 3);

    // Reset state
    idle();
    #2;
    check("rst_busy_f", {24'd0, busy_f}, 32'h0);
    check("rst_busy_n", {24'd0, busy_n}, 32'h0);
    check("rst_sc_f", {16'd0, sc_f}, 32'h0);
    check("rst_sc_s", {30'd0, sc_s}, 32'h0);
    check("rst_stall_f", {31'd0, bus_f.stall}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Vector table on the forwarding instance
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].he, vecs[i].fl, vecs[i].iv, vecs[i].wen, vecs[i].dest, vecs[i].lat,
            vecs[i].s1, vecs[i].s1u, vecs[i].s2, vecs[i].s2u);
      @(negedge clk);
      check($sformatf("v%0d_stall", i), {31'd0, bus_f.stall}, {31'd0, vecs[i].stall});
      check($sformatf("v%0d_ack", i), {31'd0, bus_f.issue_ack}, {31'd0, vecs[i].ack});
      check($sformatf("v%0d_busy", i), {24'd0, busy_f}, {24'd0, vecs[i].busy});
      check($sformatf("v%0d_sc", i), {16'd0, sc_f}, {16'd0, vecs[i].sc});
    end

    // Non-forwarding timing: issue dest3 lat3, idle, then dependent instruction held until ack
    do_reset();
    @(posedge clk); #1;
    drive(1, 0, 1, 1, 3, 3, 0, 0, 0, 0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    busy_cyc = busy_n[3] ? 1 : 0;
    stalls = 0;
    acked = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(posedge clk); #1;
      drive(1, 0, 1, 0, 0, 0, 3, 1, 0, 0);
      @(negedge clk);
      if (busy_n[3]) busy_cyc++;
      if (bus_n.issue_ack) acked = 1'b1;
      else if (bus_n.stall) stalls++;
    end
    check("nofwd_acked", {31'd0, acked}, 32'd1);
    check("nofwd_stall_cycles", stalls, 32'd2);
    check("nofwd_busy_cycles", busy_cyc, 32'd3);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("nofwd_sc", {16'd0, sc_n}, 32'd2);
    check("fwd_sc_same_stim", {16'd0, sc_f}, 32'd1);

    // Long stall, saturation, then async reset mid-countdown
    do_reset();
    @(posedge clk); #1;
    drive(1, 0, 1, 1, 1, 7, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      drive(1, 0, 1, 0, 0, 0, 1, 1, 0, 0);
    end
    @(posedge clk); #1;
    drive(1, 0, 1, 1, 6, 7, 0, 0, 0, 0);
    @(posedge clk); #1;
    drive(1, 0, 1, 0, 0, 0, 6, 1, 0, 0);
    @(negedge clk);
    check("long_sc_n", {16'd0, sc_n}, 32'd7);
    check("long_sc_f", {16'd0, sc_f}, 32'd6);
    check("sat_sc_s", {30'd0, sc_s}, 32'd3);
    check("pre_rst_busy_n", {24'd0, busy_n}, 32'h40);
    check("pre_rst_stall_n", {31'd0, bus_n.stall}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("arst_busy_n", {24'd0, busy_n}, 32'h0);
    check("arst_busy_f", {24'd0, busy_f}, 32'h0);
    check("arst_sc_n", {16'd0, sc_n}, 32'h0);
    check("arst_sc_s", {30'd0, sc_s}, 32'h0);
    check("arst_stall_n", {31'd0, bus_n.stall}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 1, 1, 2, 2, 0, 0, 0, 0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    check("post_rst_busy_n", {24'd0, busy_n}, 32'h04);
    check("post_rst_sc_n", {16'd0, sc_n}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
